relu_stream_arbiter: RTL and testbench
======================================

RELU_STREAM_ARBITER -- requirements
Module: relu_stream_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requester streams sharing one ReLU stage.
REQ-002 Parameter DATA_WIDTH, default 16: signed two's-complement sample width.
REQ-003 Parameter ID_WIDTH, default 2: requester index width; SHALL satisfy 2**ID_WIDTH >= N_REQ.
REQ-004 Port clk, input, 1: clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port req_valid, input, N_REQ: per-requester beat valid.
REQ-007 Port req_data, input, N_REQ*DATA_WIDTH: per-requester sample; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_last, input, N_REQ: per-requester end-of-packet marker.
REQ-009 Port req_ready, output, N_REQ: per-requester beat accept.
REQ-010 Port relu_data_in, output, DATA_WIDTH: sample driven to the shared ReLU stage, which has fixed 1-cycle registered latency.
REQ-011 Port relu_data_out, input, DATA_WIDTH: ReLU result, valid one cycle after issue.
REQ-012 Port m_valid, output, 1: output beat valid.
REQ-013 Port m_data, output, DATA_WIDTH: activated sample.
REQ-014 Port m_id, output, ID_WIDTH: source requester index of the beat.
REQ-015 Port m_last, output, 1: end-of-packet marker of the beat.
REQ-016 Port m_ready, input, 1: downstream accept.
REQ-017 Port busy, output, 1: high when the state is not IDLE, a beat is in flight, or the FIFO is non-empty.

Function
REQ-018 A beat transfers on an input when req_valid[i] and req_ready[i] are both high, and on the output when m_valid and m_ready are both high.
REQ-019 The FSM SHALL have states IDLE and STREAM.
REQ-020 In IDLE with any req_valid high, the FSM SHALL register grant = first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo N_REQ, and go to STREAM; with no req_valid high it SHALL stay in IDLE.
REQ-021 The FSM SHALL NOT accept beats in IDLE; every req_ready bit SHALL be 0 there.
REQ-022 In STREAM only req_ready[grant] SHALL be driven; it SHALL equal issue_ok = (fifo_count + inflight - pop) < 2, where pop = m_valid and m_ready.
REQ-023 relu_data_in SHALL equal req_data of the granted requester in STREAM, and 0 in IDLE.
REQ-024 On an input transfer, inflight SHALL be set for one cycle, registering grant as tag_id and req_last as tag_last; otherwise inflight SHALL clear.
REQ-025 When inflight is high, relu_data_out together with tag_id and tag_last SHALL be written into a 2-entry output FIFO in that cycle.
REQ-026 m_valid, m_data, m_id, m_last SHALL present the FIFO head; m_valid = (fifo_count != 0).
REQ-027 Simultaneous FIFO write and pop SHALL leave fifo_count unchanged and preserve order; the FIFO SHALL never overflow.
REQ-028 An input transfer with req_last high SHALL move the FSM to IDLE and set rr_ptr = (grant+1) mod N_REQ.
REQ-029 A granted requester SHALL hold the grant until its last beat; req_valid low on the granted requester mid-packet SHALL stall without releasing the grant.
REQ-030 With m_ready held high and the grantee continuously valid, throughput SHALL be 1 beat/cycle; latency from input transfer to m_valid SHALL be 2 cycles.
REQ-031 A single-beat packet (req_last on the first beat) SHALL be legal and returns the FSM to IDLE the next cycle.

Reset
REQ-032 While rst is high: state = IDLE, rr_ptr = 0, grant = 0, inflight = 0, fifo_count = 0; req_ready = 0, relu_data_in = 0, m_valid = 0, m_data = 0, m_id = 0, m_last = 0, busy = 0.
REQ-033 Reset asserted mid-packet SHALL discard the in-flight beat and all FIFO contents, with no output beat after deassertion until new input arrives.

Verification
REQ-034 Single requester: req 2 sends a 3-beat packet of 5, -3, 7 with m_ready=1 -> outputs 5, 0, 7 with m_id=2 and m_last only on the third beat, first m_valid 2 cycles after the first transfer.
REQ-035 Round-robin: all 4 requesters continuously valid with 2-beat packets, starting from rr_ptr=0 -> packet order 0,1,2,3,0, with no interleaving of beats within a packet.
REQ-036 Backpressure: m_ready=0 during a 4-beat stream -> exactly 2 beats are accepted and req_ready drops; on raising m_ready, all 4 beats are delivered in order with no loss or duplication.
REQ-037 Boundary values: inputs 0x8000 and 0x7FFF -> outputs 0x0000 and 0x7FFF; input 0x0000 -> 0x0000.
REQ-038 Mid-packet stall: the grantee drops req_valid for 3 cycles while req 1 is valid -> the grant is held, req_ready[1] stays 0, and the packet completes before req 1 is served.
REQ-039 Reset mid-stream: rst is pulsed for 1 cycle with 2 beats in the FIFO and 1 in flight -> m_valid=0 and busy=0 after reset, and the next grant searches from requester 0.

Source files
------------

// File: rtl/relu_stream_arbiter.sv
// rtl/relu_stream_arbiter.sv - round-robin packet arbiter feeding a shared 1-cycle ReLU stage
// Grants whole packets, tags each issued beat, and reorders nothing: results land in a 2-entry FIFO.
module relu_stream_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       relu_data_in,
    input  logic [DATA_WIDTH-1:0]       relu_data_out,
    output logic                        m_valid,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [ID_WIDTH-1:0]         m_id,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   tag_id_q;
    logic                  tag_last_q;
    logic                  inflight_q;
    logic [1:0]            fifo_count_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [ID_WIDTH-1:0]   fifo_id_q   [2];
    logic                  fifo_last_q [2];

    logic [DATA_WIDTH-1:0] req_lane [N_REQ];
    logic [ID_WIDTH-1:0]   rr_pick;
    logic [ID_WIDTH-1:0]   rr_idx_w;
    int                    rr_idx;
    logic                  pop;
    logic                  issue_ok;
    logic                  in_xfer;
    logic [2:0]            occupancy;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign req_lane[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        rr_pick  = rr_ptr_q;
        rr_idx   = 0;
        rr_idx_w = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            rr_idx_w = ID_WIDTH'(rr_idx);
            if (req_valid[rr_idx_w]) rr_pick = rr_idx_w;
        end
    end

    assign m_valid = (fifo_count_q != 2'd0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_id    = fifo_id_q[rd_ptr_q];
    assign m_last  = fifo_last_q[rd_ptr_q];
    assign pop     = m_valid & m_ready;
    assign busy    = (state_q != IDLE) | inflight_q | m_valid;

    // Issue only if the FIFO is guaranteed a slot when this beat returns from the ReLU stage.
    assign occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_ok  = (occupancy < 3'd2);
    assign in_xfer   = (state_q == STREAM) && issue_ok && req_valid[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        req_ready    = '0;
        relu_data_in = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                req_ready[grant_q] = issue_ok;
                relu_data_in       = req_lane[grant_q];
                if (in_xfer && req_last[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            tag_id_q     <= '0;
            tag_last_q   <= 1'b0;
            inflight_q   <= 1'b0;
            fifo_count_q <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            inflight_q <= in_xfer;
            if (in_xfer) begin
                tag_id_q   <= grant_q;
                tag_last_q <= req_last[grant_q];
            end
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= relu_data_out;
                fifo_id_q[wr_ptr_q]   <= tag_id_q;
                fifo_last_q[wr_ptr_q] <= tag_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({inflight_q, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// tb/tb_relu_stream_arbiter.sv - scoreboard bench for relu_stream_arbiter
module tb_relu_stream_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*W-1:0]  req_data;
    logic [W-1:0]    relu_data_in, relu_data_out, m_data;
    logic            m_valid, m_last, m_ready, busy;
    logic [IW-1:0]   m_id;

    beat_t        src_q [N][$];
    beat_t        exp_q [N][$];
    int           out_order [$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           acc_cnt [N] = '{default: 0};
    logic [N-1:0] acc = '0;
    logic [N-1:0] hold = '0;
    logic [N-1:0] hold_force = '0;
    int           mr_mode = 1;
    bit           rand_stall = 1'b0;
    bit           in_pkt = 1'b0;
    logic [IW-1:0] cur_id = '0;

    always #5 clk = ~clk;

    relu_stream_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .relu_data_in(relu_data_in), .relu_data_out(relu_data_out),
        .m_valid(m_valid), .m_data(m_data), .m_id(m_id), .m_last(m_last), .m_ready(m_ready),
        .busy(busy)
    );

    // External ReLU stage: one register, negative samples clamp to zero.
    logic [W-1:0] relu_q = '0;
    always @(posedge clk) relu_q <= relu_data_in[W-1] ? '0 : relu_data_in;
    assign relu_data_out = relu_q;

    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] d);
        if ($signed(d) < 0) return '0;
        return d;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic push_beat(input int id, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[id].push_back(b);
    endtask

    task automatic enqueue_random(input int id, input int len);
        logic [W-1:0] d;
        for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 5))
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                2:       d = 16'h0000;
                3:       d = 16'hFFFF;
                default: d = W'($urandom);
            endcase
            push_beat(id, d, k == len - 1);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        mr_mode = 1;
        rand_stall = 1'b0;
        hold_force = '0;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (all_empty() && !busy && !m_valid) done = 1'b1;
            else tick();
        end
        check(done, name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_order(input string name, input int e0, input int e1, input int n);
        check(out_order.size() >= n, {name, "_count"}, out_order.size(), n);
        check((out_order.size() > 0 ? out_order[0] : -1) == e0, {name, "_first"},
              out_order.size() > 0 ? out_order[0] : -1, e0);
        check((out_order.size() > 1 ? out_order[1] : -1) == e1, {name, "_second"},
              out_order.size() > 1 ? out_order[1] : -1, e1);
    endtask

    // Driver: presents queue heads, records accepted beats into the scoreboard.
    initial begin
        beat_t b, e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        m_ready   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                hold[i] = rand_stall ? ($urandom_range(0, 3) == 0) : hold_force[i];
                if (src_q[i].size() > 0) begin
                    req_valid[i]         = !hold[i];
                    req_data[i*W +: W]   = src_q[i][0].data;
                    req_last[i]          = src_q[i][0].last;
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*W +: W]   = '0;
                    req_last[i]          = 1'b0;
                end
            end
            m_ready = (mr_mode == 0) ? 1'b0 : (mr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            acc = req_valid & req_ready & {N{!rst}};
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    b = src_q[i].pop_front();
                    e.data = relu_ref(b.data);
                    e.last = b.last;
                    exp_q[i].push_back(e);
                    acc_cnt[i]++;
                end
            end
        end
    end

    // Monitor: pops the expected beat for the presented id on every output transfer.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check($countones(req_ready) <= 1, "ready_onehot", {28'd0, req_ready}, 32'd0);
                if (m_valid && m_ready) begin
                    if (exp_q[m_id].size() == 0) begin
                        check(1'b0, "unexpected_beat", {16'd0, m_data}, {30'd0, m_id});
                    end else begin
                        e = exp_q[m_id].pop_front();
                        check(m_data == e.data, "out_data", {16'd0, m_data}, {16'd0, e.data});
                        check(m_last == e.last, "out_last", {31'd0, m_last}, {31'd0, e.last});
                    end
                    if (in_pkt) check(m_id == cur_id, "interleave", {30'd0, m_id}, {30'd0, cur_id});
                    if (m_last) begin
                        in_pkt = 1'b0;
                        out_order.push_back(int'(m_id));
                    end else begin
                        in_pkt = 1'b1;
                        cur_id = m_id;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int acc_c [$];
        int first_mv, a0, bound;
        repeat (3) tick();
        check(req_ready == '0, "rst_req_ready", {28'd0, req_ready}, 32'd0);
        check(relu_data_in == '0, "rst_relu_in", {16'd0, relu_data_in}, 32'd0);
        check(m_valid == 1'b0, "rst_m_valid", {31'd0, m_valid}, 32'd0);
        check(m_data == '0, "rst_m_data", {16'd0, m_data}, 32'd0);
        check(m_id == '0, "rst_m_id", {30'd0, m_id}, 32'd0);
        check(m_last == 1'b0, "rst_m_last", {31'd0, m_last}, 32'd0);
        check(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check(req_ready == '0, "idle_no_ready", {28'd0, req_ready}, 32'd0);

        // Round robin from pointer 0 with everyone continuously valid.
        out_order.delete();
        for (int i = 0; i < N; i++) enqueue_random(i, 2);
        enqueue_random(0, 2);
        drain("rr_drain");
        check(out_order.size() == 5, "rr_count", out_order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            a0 = (k < out_order.size()) ? out_order[k] : -1;
            check(a0 == (k % 4), "rr_order", a0, k % 4);
        end

        // Single requester: 5, -3, 7 on requester 2.
        out_order.delete();
        push_beat(2, 16'd5, 1'b0);
        push_beat(2, 16'hFFFD, 1'b0);
        push_beat(2, 16'd7, 1'b1);
        first_mv = -1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (acc[2]) acc_c.push_back(cyc);
            if (m_valid && first_mv < 0) first_mv = cyc;
        end
        a0 = (acc_c.size() > 0) ? acc_c[0] : -100;
        check(acc_c.size() == 3, "single_accepts", acc_c.size(), 3);
        check(acc_c.size() == 3 && acc_c[2] - a0 == 2, "single_throughput",
              acc_c.size() == 3 ? acc_c[2] - a0 : -1, 2);
        check(first_mv - a0 == 2, "single_latency", first_mv - a0, 2);
        drain("single_drain");
        check_order("single", 2, -1, 1);

        // Boundary samples.
        push_beat(1, 16'h8000, 1'b0);
        push_beat(1, 16'h7FFF, 1'b0);
        push_beat(1, 16'h0000, 1'b1);
        push_beat(3, 16'hFFFF, 1'b1);
        drain("boundary_drain");

        // Backpressure: only two beats fit before the FIFO closes the gate.
        mr_mode = 0;
        a0 = acc_cnt[0];
        enqueue_random(0, 4);
        repeat (8) tick();
        check(acc_cnt[0] - a0 == 2, "bp_accepted", acc_cnt[0] - a0, 2);
        check(req_ready == '0, "bp_ready_low", {28'd0, req_ready}, 32'd0);
        check(m_valid == 1'b1, "bp_m_valid", {31'd0, m_valid}, 32'd1);
        drain("bp_drain");
        check(acc_cnt[0] - a0 == 4, "bp_total", acc_cnt[0] - a0, 4);

        // Mid-packet stall on requester 0 while requester 1 waits.
        out_order.delete();
        a0 = acc_cnt[0];
        enqueue_random(0, 4);
        bound = 0;
        while (acc_cnt[0] == a0 && bound < 20) begin
            tick();
            bound++;
        end
        check(acc_cnt[0] != a0, "stall_first_beat", acc_cnt[0] - a0, 1);
        hold_force[0] = 1'b1;
        enqueue_random(1, 2);
        repeat (3) begin
            tick();
            check(req_ready[1] == 1'b0, "stall_ready1", {31'd0, req_ready[1]}, 32'd0);
        end
        hold_force[0] = 1'b0;
        drain("stall_drain");
        check_order("stall", 0, 1, 2);

        // Reset mid-stream; leave rr_ptr at 3 first so the restart from 0 is visible.
        enqueue_random(2, 2);
        drain("pre_reset_drain");
        mr_mode = 0;
        a0 = acc_cnt[2];
        enqueue_random(2, 4);
        bound = 0;
        while (acc_cnt[2] - a0 < 2 && bound < 20) begin
            tick();
            bound++;
        end
        tick();
        tick();
        check(m_valid == 1'b1, "prereset_m_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        in_pkt = 1'b0;
        tick();
        rst = 1'b0;
        mr_mode = 1;
        repeat (3) begin
            tick();
            check(m_valid == 1'b0, "postreset_m_valid", {31'd0, m_valid}, 32'd0);
            check(busy == 1'b0, "postreset_busy", {31'd0, busy}, 32'd0);
        end
        out_order.delete();
        enqueue_random(3, 1);
        enqueue_random(1, 1);
        drain("postreset_drain");
        check_order("postreset_rr", 1, 3, 2);

        // Randomized traffic with random backpressure and stalls.
        mr_mode = 2;
        rand_stall = 1'b1;
        for (int p = 0; p < 80; p++) begin
            enqueue_random($urandom_range(0, N - 1), $urandom_range(1, 4));
            repeat ($urandom_range(0, 4)) tick();
        end
        drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
